// File: rtl/mux_serializer_pkg.sv
// Shared widths and FSM encodings for the parallel-to-serial sender.
package mux_serializer_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
endpackage

// File: rtl/mux_serializer_multiplex.sv
// 8:1 bit selector; picks In[Sel] combinationally.
module multiplex
  import mux_serializer_pkg::*;
(
  input  logic [DATA_W-1:0] In,
  input  logic [SEL_W-1:0]  Sel,
  output logic              Out
);
  assign Out = In[Sel];
endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial sender: latches a word, then walks the multiplex select
// through all eight bits, holding each for CLKS_PER_BIT clocks.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [SEL_W-1:0]  Sel,
  output logic              Ser_out,
  output logic              Ser_valid,
  output logic              Frame_start,
  output logic              Frame_done,
  output logic              Busy
);
  localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [SEL_W-1:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

  logic              state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mux_out;
  logic              div_tc;
  logic              handshake;

  multiplex u_mux (
    .In  (hold_q),
    .Sel (sel_q),
    .Out (mux_out)
  );

  assign div_tc      = (div_q == DIV_LAST);
  assign Busy        = (state_q == ST_SHIFT);
  assign Ser_valid   = Busy;
  assign Ser_out     = Busy & mux_out;
  assign Frame_start = Busy && (cnt_q == 3'd0) && (div_q == '0);
  assign Frame_done  = Busy && (cnt_q == 3'd7) && div_tc;
  // Reset holds In_ready low even though the state already reads IDLE.
  assign In_ready    = rst_n & ((state_q == ST_IDLE) | Frame_done);
  assign handshake   = In_valid & In_ready;
  assign Sel         = sel_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (handshake) begin
        state_d = ST_SHIFT;
        hold_d  = In_data;
        sel_d   = SEL_START;
        div_d   = '0;
        cnt_d   = 3'd0;
      end
    end else if (div_tc) begin
      div_d = '0;
      if (cnt_q == 3'd7) begin
        sel_d = SEL_START;
        cnt_d = 3'd0;
        if (handshake) begin
          hold_d = In_data;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        sel_d = (MSB_FIRST != 0) ? sel_q - 3'd1 : sel_q + 3'd1;
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      sel_q   <= SEL_START;
      div_q   <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
